sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Synchronous FIFO controller that sequences an external dual_ram_module (1 write port, 1 read port, shared clock) as a first-in-first-out buffer.
- Owns the write/read pointers, occupancy count and status flags.
- Gates the RAM's i_ena/i_enb strobes and drives its i_waddr/i_raddr.
- Sits between a producer/consumer pair and the RAM instance; the RAM holds the data storage only.

Parameters:
P_DATA_WIDTH, 4, data word width; must match the RAM instance.
P_ADDR_DEPTH, 128, RAM depth in words; power of two, ≥ 4; must match the RAM instance.
P_AFULL_THRESH, 120, o_almost_full asserts when count ≥ this value.
P_AEMPTY_THRESH, 8, o_almost_empty asserts when count ≤ this value.
Derived: AW = clog2(P_ADDR_DEPTH).

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  asynchronous, active-low reset (asserted at 0)
i_wr_en  in  1  producer write request
i_wr_data  in  P_DATA_WIDTH  write data
i_rd_en  in  1  consumer read request
o_rd_data  out  P_DATA_WIDTH  read data; valid when o_rd_valid=1
o_rd_valid  out  1  read-data qualifier
o_full  out  1  count == P_ADDR_DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count ≥ P_AFULL_THRESH
o_almost_empty  out  1  count ≤ P_AEMPTY_THRESH
o_count  out  AW+1  occupancy, 0..P_ADDR_DEPTH
o_overflow  out  1  one-cycle pulse: write requested while full
o_underflow  out  1  one-cycle pulse: read requested while empty
o_ram_ena  out  1  to RAM i_ena
o_ram_wdata  out  P_DATA_WIDTH  to RAM i_wdata
o_ram_waddr  out  AW  to RAM i_waddr
o_ram_enb  out  1  to RAM i_enb
o_ram_raddr  out  AW  to RAM i_raddr
i_ram_rdata  in  P_DATA_WIDTH  from RAM o_rdata

Behaviour:
- Reset (i_rst=0, asynchronous, no clock needed):
  - Pointers and count = 0.
  - o_empty=1, o_almost_empty=1; o_full=0, o_almost_full=0.
  - o_rd_valid=0, o_overflow=0, o_underflow=0.
  - Stored RAM contents are not cleared and are treated as invalid.
  - Reset mid-operation discards all entries and any in-flight read; o_rd_valid drops immediately.
- Write accept: wr_acc = i_wr_en & ~o_full.
  - o_ram_ena = wr_acc, o_ram_waddr = wptr, o_ram_wdata = i_wr_data, all combinational.
  - wptr increments on wr_acc and wraps P_ADDR_DEPTH-1 → 0.
- Read accept: rd_acc = i_rd_en & ~o_empty.
  - o_ram_enb = rd_acc, o_ram_raddr = rptr, both combinational.
  - rptr increments on rd_acc with the same wrap.
- Read latency: the RAM output is registered (1 cycle).
  - o_rd_valid is rd_acc registered, i.e. high exactly 1 cycle after o_ram_enb.
  - o_rd_data = i_ram_rdata passthrough.
  - Back-to-back reads give one valid word per cycle.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Flags:
  - o_full, o_empty, o_almost_full and o_almost_empty are registered and computed from next-count.
  - They are therefore correct in the cycle after the update.
- Simultaneous request at full: read accepted, write rejected (o_overflow=1); count becomes P_ADDR_DEPTH-1.
- Simultaneous request at empty: write accepted, read rejected (o_underflow=1); count becomes 1.
  - Data is not forwarded; that word is readable from the next cycle.
- Address collision cannot occur: accepted read and write target the same address only when count is 0 or P_ADDR_DEPTH, and in those states one of the two is blocked.
- o_overflow = i_wr_en & o_full, registered one-cycle pulse. o_underflow = i_rd_en & o_empty, likewise. State is unchanged on a rejected request.
- o_count is registered and equals the number of words written and not yet read.

Test Plan:
1. Reset release, write 10 words 1..10 then read 10 → o_ram_waddr 0..9, o_ram_raddr 0..9; o_rd_data 1..10 each 1 cycle after o_ram_enb; o_count ends at 0; o_empty=1 the cycle after the last read.
2. 128 consecutive writes → o_almost_full=1 after the 120th; o_full=1 and o_count=128 after the 128th; a 129th write gives o_overflow pulse, o_ram_ena=0, count stays 128.
3. Read on empty after reset → o_ram_enb=0, o_underflow pulse, o_rd_valid stays 0; simultaneous rd+wr at empty → only the write accepted, count=1.
4. Fill to 5, then 20 cycles of simultaneous rd+wr → o_count stays 5; output sequence equals input order; simultaneous rd+wr at full → count=127, o_overflow pulse.
5. Wrap: 300 interleaved writes/reads with random gaps → pointers wrap 127→0 twice; no data loss or reorder; all flags consistent with the reference count model.
6. Assert i_rst=0 asynchronously mid-burst with count=40 and a read in flight → all outputs at reset values before the next edge; a subsequent write/read of value 7 returns 7 from address 0.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller for an external 1W/1R RAM with a registered read port.
// Keeps the pointers, occupancy and status flags, and drives the RAM strobes and addresses.
module sync_fifo_ctrl #(
    parameter int P_DATA_WIDTH    = 4,
    parameter int P_ADDR_DEPTH    = 128,
    parameter int P_AFULL_THRESH  = 120,
    parameter int P_AEMPTY_THRESH = 8,
    localparam int AW             = $clog2(P_ADDR_DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [P_DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_rd_en,
    output logic [P_DATA_WIDTH-1:0] o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [AW:0]             o_count,
    output logic                    o_overflow,
    output logic                    o_underflow,
    output logic                    o_ram_ena,
    output logic [P_DATA_WIDTH-1:0] o_ram_wdata,
    output logic [AW-1:0]           o_ram_waddr,
    output logic                    o_ram_enb,
    output logic [AW-1:0]           o_ram_raddr,
    input  logic [P_DATA_WIDTH-1:0] i_ram_rdata
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(P_ADDR_DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(P_AFULL_THRESH);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(P_AEMPTY_THRESH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q, afull_q, aempty_q;
    logic          rd_valid_q, overflow_q, underflow_q;
    logic          wr_acc, rd_acc;

    assign wr_acc = i_wr_en & ~full_q;
    assign rd_acc = i_rd_en & ~empty_q;

    assign o_ram_ena   = wr_acc;
    assign o_ram_waddr = wptr_q;
    assign o_ram_wdata = i_wr_data;
    assign o_ram_enb   = rd_acc;
    assign o_ram_raddr = rptr_q;

    assign o_rd_data      = i_ram_rdata;
    assign o_rd_valid     = rd_valid_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_count        = count_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wptr_d  = wr_acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd_acc ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Flags are derived from next-count so they line up with the registered count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == '0);
            afull_q     <= (count_d >= AFULL_C);
            aempty_q    <= (count_d <= AEMPTY_C);
            rd_valid_q  <= rd_acc;
            overflow_q  <= i_wr_en & full_q;
            underflow_q <= i_rd_en & empty_q;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized scoreboard bench for sync_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
// Read data is checked by a separate monitor that pops expected words whenever o_rd_valid is high.
module tb_sync_fifo_ctrl;

    localparam int DW    = 4;
    localparam int DEPTH = 128;
    localparam int AFT   = 120;
    localparam int AET   = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rstN;
    logic          wrEn;
    logic [DW-1:0] wrData;
    logic          rdEn;
    logic [DW-1:0] rdData;
    logic          rdValid, full, empty, aFull, aEmpty, ovf, unf;
    logic [AW:0]   count;
    logic          ramEna, ramEnb;
    logic [DW-1:0] ramWdata, ramRdata;
    logic [AW-1:0] ramWaddr, ramRaddr;

    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0] modelQ [$];
    logic [DW-1:0] expQ [$];
    int            wrTotal;
    int            rdTotal;
    int            checks;
    int            errors;

    sync_fifo_ctrl #(
        .P_DATA_WIDTH(DW),
        .P_ADDR_DEPTH(DEPTH),
        .P_AFULL_THRESH(AFT),
        .P_AEMPTY_THRESH(AET)
    ) dut (
        .i_clk(clk),
        .i_rst(rstN),
        .i_wr_en(wrEn),
        .i_wr_data(wrData),
        .i_rd_en(rdEn),
        .o_rd_data(rdData),
        .o_rd_valid(rdValid),
        .o_full(full),
        .o_empty(empty),
        .o_almost_full(aFull),
        .o_almost_empty(aEmpty),
        .o_count(count),
        .o_overflow(ovf),
        .o_underflow(unf),
        .o_ram_ena(ramEna),
        .o_ram_wdata(ramWdata),
        .o_ram_waddr(ramWaddr),
        .o_ram_enb(ramEnb),
        .o_ram_raddr(ramRaddr),
        .i_ram_rdata(ramRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external dual-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ramEna) mem[ramWaddr] <= ramWdata;
        if (ramEnb) ramRdata <= mem[ramRaddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid read word must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rdValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_data unexpected valid actual=%0d expected=none at %0t", rdData, $time);
            end else begin
                checkOutput("rd_data", 32'(rdData), 32'(expQ.pop_front()));
            end
        end
    end

    task automatic checkFlags(input logic expOvf, input logic expUnf, input logic expValid);
        int n;
        n = modelQ.size();
        checkOutput("count", 32'(count), n);
        checkOutput("full", 32'(full), 32'(n == DEPTH));
        checkOutput("empty", 32'(empty), 32'(n == 0));
        checkOutput("almost_full", 32'(aFull), 32'(n >= AFT));
        checkOutput("almost_empty", 32'(aEmpty), 32'(n <= AET));
        checkOutput("overflow", 32'(ovf), 32'(expOvf));
        checkOutput("underflow", 32'(unf), 32'(expUnf));
        checkOutput("rd_valid", 32'(rdValid), 32'(expValid));
    endtask

    // One cycle: drive at negedge, check RAM-side strobes, update model, check registered state after posedge.
    task automatic applyStimulus(input logic wr, input logic [DW-1:0] data, input logic rd);
        logic wrAcc, rdAcc;
        @(negedge clk);
        wrEn   = wr;
        wrData = data;
        rdEn   = rd;
        #1;
        wrAcc = wr && (modelQ.size() != DEPTH);
        rdAcc = rd && (modelQ.size() != 0);
        checkOutput("ram_ena", 32'(ramEna), 32'(wrAcc));
        checkOutput("ram_enb", 32'(ramEnb), 32'(rdAcc));
        if (wrAcc) begin
            checkOutput("ram_waddr", 32'(ramWaddr), wrTotal % DEPTH);
            checkOutput("ram_wdata", 32'(ramWdata), 32'(data));
        end
        if (rdAcc) checkOutput("ram_raddr", 32'(ramRaddr), rdTotal % DEPTH);
        if (rdAcc) begin
            expQ.push_back(modelQ.pop_front());
            rdTotal++;
        end
        if (wrAcc) begin
            modelQ.push_back(data);
            wrTotal++;
        end
        @(posedge clk);
        #1;
        checkFlags(wr && !wrAcc, rd && !rdAcc, rdAcc);
    endtask

    task automatic drainAll();
        while (modelQ.size() > 0) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_almost_empty", 32'(aEmpty), 1);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_almost_full", 32'(aFull), 0);
        checkOutput("rst_rd_valid", 32'(rdValid), 0);
        checkOutput("rst_overflow", 32'(ovf), 0);
        checkOutput("rst_underflow", 32'(unf), 0);
        checkOutput("rst_ram_ena", 32'(ramEna), 0);
        checkOutput("rst_ram_enb", 32'(ramEnb), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        wrTotal = 0;
        rdTotal = 0;
        wrEn    = 1'b0;
        rdEn    = 1'b0;
        wrData  = '0;
        rstN    = 1'b0;
        #12;
        checkResetState();
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] basic write/read of 1..10");
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        $display("[TB] fill to full, overflow, simultaneous at full");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
        applyStimulus(1'b1, DW'($urandom), 1'b0);
        applyStimulus(1'b1, DW'($urandom), 1'b1);
        drainAll();

        $display("[TB] underflow and simultaneous at empty");
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, 4'hA, 1'b1);
        drainAll();

        $display("[TB] steady state at count 5");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'($urandom), 1'b1);
        drainAll();

        $display("[TB] random interleaving with pointer wrap");
        for (int i = 0; i < 700; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 50);
        end
        checkOutput("wrap_writes", 32'(wrTotal >= 2 * DEPTH + 10), 1);
        drainAll();

        $display("[TB] async reset with a read in flight");
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        wrEn = 1'b0;
        rdEn = 1'b0;
        #1;
        rstN = 1'b0;
        #1;
        checkResetState();
        modelQ.delete();
        expQ.delete();
        wrTotal = 0;
        rdTotal = 0;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, 4'd7, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
